apb_rr_master: RTL and testbench
================================

Name: apb_rr_master

Overview:
Round-robin APB master that shares one APB3 bus to the dual-port memory slave (apb_dpmem) between NUM_REQ local requesters.
- Each requester presents a simple valid/ready command (addr, write, wdata).
- The block arbitrates between requesters, sequences the APB IDLE/SETUP/ACCESS phases and returns read data or error per requester.
- It sits between the on-chip initiators and the APB slave port.
- It bounds slave stalls with a wait-state timeout.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 32, PADDR / req address width
DATA_WIDTH, 32, PWDATA/PRDATA width
TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY before abort (>=2)

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESETn  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_write  in  NUM_REQ  per-requester 1=write 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
req_ready  out  NUM_REQ  one-hot accept strobe (combinational)
rsp_valid  out  NUM_REQ  one-hot completion pulse (registered)
rsp_rdata  out  DATA_WIDTH  read data for completing transfer
rsp_err  out  1  completion error (PSLVERR or timeout)
PADDR  out  ADDR_WIDTH  APB address
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (PRESETn low at a PCLK edge): state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, timeout counter all 0. Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has priority first.
- FSM states IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If any req_valid, the winner is the first valid index scanning last_grant+1, last_grant+2, ... mod NUM_REQ.
  - req_ready[winner]=1 combinationally in this cycle only. All other req_ready bits are 0, and all are 0 in SETUP/ACCESS.
  - On the edge: latch addr/write/wdata of the winner into PADDR/PWRITE/PWDATA, last_grant<=winner, go to SETUP.
  - With no valid: stay IDLE; PADDR/PWRITE/PWDATA hold their last values.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle, then go to ACCESS. Clear the timeout counter.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stable through SETUP and ACCESS.
  - PREADY=1: transfer completes on this edge.
    - rsp_valid[grant]<=1 for one cycle.
    - rsp_err<=PSLVERR.
    - rsp_rdata<=PRDATA for reads, 0 for writes.
    - Go to IDLE.
  - PREADY=0: increment counter. When the counter reaches TIMEOUT-1 with PREADY still 0, abort on that edge: rsp_valid[grant]=1, rsp_err=1, rsp_rdata=0, go to IDLE. The ACCESS phase therefore lasts at most TIMEOUT cycles.
- Latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 (zero wait states).
  - Minimum 3 cycles per transfer.
  - One mandatory IDLE cycle between transfers; no back-to-back ACCESS→SETUP.
- rsp_rdata/rsp_err are valid only while rsp_valid is set and hold otherwise.
- Requester dropping req_valid before acceptance: no transfer; arbitration re-evaluates each IDLE cycle.
- Requester changing req_* after acceptance: no effect on the current transfer.
- Simultaneous requests are served round-robin; a requester waits at most NUM_REQ-1 transfers.
- Reset during SETUP/ACCESS: synchronous abort. PSEL/PENABLE are 0 from the next cycle, no rsp_valid is issued for the aborted transfer, and the pointer is reset.

Test Plan:
- Req0 write addr 0x10 data 0xDEADBEEF, PREADY tied 1 -> req_ready[0] at cycle N; PSEL N+1..N+2, PENABLE N+2; rsp_valid[0] at N+3, rsp_err=0, rsp_rdata=0.
- Req1 read addr 0x10, slave holds PREADY low 2 cycles then returns 0xDEADBEEF -> ACCESS lasts 3 cycles, PADDR stable; rsp_valid[1] with rsp_rdata=0xDEADBEEF.
- Req0 and req1 held valid continuously, 4 transfers -> grant order 0,1,0,1; one IDLE cycle (PSEL=0) between each.
- PREADY stuck 0, TIMEOUT=16 -> ACCESS exactly 16 cycles, then rsp_valid with rsp_err=1, rsp_rdata=0; bus returns to IDLE.
- Read completing with PREADY=1, PSLVERR=1 -> rsp_err=1 pulse; next transfer rsp_err=0.
- PRESETn low for one cycle during ACCESS -> next cycle PSEL=PENABLE=0, no rsp_valid; first post-reset simultaneous request from 0 and 1 grants requester 0.

Source files
------------

// File: rtl/apb_rr_master_if.sv
// APB3 bus bundle between the round-robin master and the memory slave.
// The master modport drives address/control/write data; the slave answers.
interface apb_rr_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin APB3 master: arbitrates NUM_REQ valid/ready requesters onto one APB bus,
// sequences IDLE/SETUP/ACCESS and returns a one-hot completion with data or error.
module apb_rr_master #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    apb_rr_master_if.master               apb
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [CNT_W-1:0] timeout_cnt;
    logic [IDX_W-1:0] winner;
    logic             found;
    int               scan_idx;

    // First valid requester after the one served last, wrapping modulo NUM_REQ.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        winner   = last_grant;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = IDX_W'(scan_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    // During SETUP/ACCESS last_grant already names the requester being served.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register sees pre-edge values regardless of statement order.
            state       <= IDLE;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            timeout_cnt <= '0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        apb.PADDR   <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        apb.PWDATA  <= req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        apb.PWRITE  <= req_write[winner];
                        apb.PSEL    <= 1'b1;
                        apb.PENABLE <= 1'b0;
                        last_grant  <= winner;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    apb.PENABLE <= 1'b1;
                    timeout_cnt <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (apb.PREADY) begin
                        rsp_valid[last_grant] <= 1'b1;
                        rsp_err     <= apb.PSLVERR;
                        rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state       <= IDLE;
                    end else if (timeout_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Counter starts at 0 in the first ACCESS cycle, so this caps ACCESS at TIMEOUT cycles.
                        rsp_valid[last_grant] <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                default: begin
                    apb.PSEL    <= 1'b0;
                    apb.PENABLE <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// Scoreboard bench for apb_rr_master: requester queues feed the DUT, a slave model
// answers on the APB bus, and expected completions are queued at acceptance.
module tb_apb_rr_master;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int TR = 32;

    logic             PCLK = 1'b0;
    logic             PRESETn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;

    apb_rr_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_rr_master #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    cmd_t q0[$];
    cmd_t q1[$];
    exp_t sb_q[$];

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    int  slv_wait  = 0;
    bit  slv_stuck = 1'b0;
    bit  slv_err   = 1'b0;

    int  tests_run    = 0;
    int  tests_failed = 0;

    logic          t_psel  [TR];
    logic          t_pen   [TR];
    logic [NR-1:0] t_ready [TR];
    logic [NR-1:0] t_rsp   [TR];
    logic          t_err   [TR];
    logic [AW-1:0] t_paddr [TR];
    logic          t_pwr   [TR];
    logic [DW-1:0] t_pwdata[TR];

    // Requester driver: notes acceptance at the negedge, advances its queue after the edge.
    initial begin : driver
        int   acc;
        cmd_t c;
        exp_t e;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        forever begin
            @(negedge PCLK);
            acc = -1;
            if (req_ready[0] && q0.size() > 0) acc = 0;
            else if (req_ready[1] && q1.size() > 0) acc = 1;
            if (acc >= 0) begin
                c = (acc == 0) ? q0[0] : q1[0];
                e.idx = acc;
                if (slv_stuck) begin
                    e.err   = 1'b1;
                    e.rdata = '0;
                end else if (c.write) begin
                    e.err   = slv_err;
                    e.rdata = '0;
                    ref_mem[c.addr] = c.data;
                end else begin
                    e.err   = slv_err;
                    e.rdata = ref_mem.exists(c.addr) ? ref_mem[c.addr] : 32'h0;
                end
                sb_q.push_back(e);
            end
            @(posedge PCLK);
            #1;
            if (acc == 0) void'(q0.pop_front());
            if (acc == 1) void'(q1.pop_front());
            req_valid[0] = (q0.size() > 0);
            req_valid[1] = (q1.size() > 0);
            if (q0.size() > 0) begin
                req_write[0] = q0[0].write; req_addr[0 +: AW] = q0[0].addr; req_wdata[0 +: DW] = q0[0].data;
            end
            if (q1.size() > 0) begin
                req_write[1] = q1[0].write; req_addr[AW +: AW] = q1[0].addr; req_wdata[DW +: DW] = q1[0].data;
            end
        end
    end

    // Slave model: wait states per ACCESS, optional stuck PREADY and PSLVERR.
    initial begin : slave
        int acc_cnt;
        bit rdy;
        acc_cnt     = 0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = 32'hA5A5_5A5A;
        forever begin
            @(negedge PCLK);
            if (apb.PSEL && apb.PENABLE) begin
                acc_cnt++;
                rdy = !slv_stuck && (acc_cnt > slv_wait);
                apb.PREADY  = rdy;
                apb.PSLVERR = rdy && slv_err;
                if (rdy && !apb.PWRITE)
                    apb.PRDATA = slv_mem.exists(apb.PADDR) ? slv_mem[apb.PADDR] : 32'h0;
                else
                    apb.PRDATA = 32'hA5A5_5A5A;
                if (rdy && apb.PWRITE) slv_mem[apb.PADDR] = apb.PWDATA;
            end else begin
                acc_cnt     = 0;
                apb.PREADY  = 1'b0;
                apb.PSLVERR = 1'b0;
                apb.PRDATA  = 32'hA5A5_5A5A;
            end
        end
    end

    // Scoreboard: every completion pulse pops and compares one expected response.
    initial begin : monitor
        exp_t          e;
        logic [NR-1:0] ev;
        forever begin
            @(negedge PCLK);
            if (rsp_valid !== '0) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b with no transfer outstanding", rsp_valid);
                end else begin
                    e  = sb_q.pop_front();
                    ev = NR'(1) << e.idx;
                    if (rsp_valid !== ev || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        tests_failed++;
                        $display("FAIL rsp: got valid=%b rdata=%h err=%b expected valid=%b rdata=%h err=%b",
                                 rsp_valid, rsp_rdata, rsp_err, ev, e.rdata, e.err);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic trace(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            t_psel[i]   = apb.PSEL;
            t_pen[i]    = apb.PENABLE;
            t_ready[i]  = req_ready;
            t_rsp[i]    = rsp_valid;
            t_err[i]    = rsp_err;
            t_paddr[i]  = apb.PADDR;
            t_pwr[i]    = apb.PWRITE;
            t_pwdata[i] = apb.PWDATA;
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge PCLK);
            if (q0.size() == 0 && q1.size() == 0 && sb_q.size() == 0 && !apb.PSEL) done = 1'b1;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_idle: traffic still pending after %0d cycles, sb=%0d", budget, sb_q.size());
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        tests_run++;
        if ({apb.PSEL, apb.PENABLE, apb.PWRITE, rsp_err} !== 4'b0 || apb.PADDR !== '0 ||
            apb.PWDATA !== '0 || rsp_valid !== '0 || rsp_rdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rsp=%b rdata=%h err=%b required all 0",
                     apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, rsp_valid, rsp_rdata, rsp_err);
        end
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        tests_run++;
        if (apb.PSEL !== 1'b0 || req_ready !== '0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: psel=%b req_ready=%b required 0/00", apb.PSEL, req_ready);
        end
    endtask

    task automatic test_write();
        int c;
        slv_wait = 0;
        q0.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF});
        trace(8);
        c = -1;
        for (int i = 3; i >= 0; i--) if (t_ready[i] === 2'b01) c = i;
        tests_run++;
        if (c < 0) begin
            tests_failed++;
            $display("FAIL write_accept: req_ready[0] never seen, first=%b", t_ready[0]);
        end else begin
            tests_run++;
            if (t_psel[c] !== 1'b0 || t_psel[c+1] !== 1'b1 || t_pen[c+1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL write_setup: psel N=%b N+1=%b pen N+1=%b required 0 1 0", t_psel[c], t_psel[c+1], t_pen[c+1]);
            end
            tests_run++;
            if (t_psel[c+2] !== 1'b1 || t_pen[c+2] !== 1'b1 || t_rsp[c+2] !== 2'b00) begin
                tests_failed++;
                $display("FAIL write_access: psel=%b pen=%b rsp=%b at N+2 required 1 1 00", t_psel[c+2], t_pen[c+2], t_rsp[c+2]);
            end
            tests_run++;
            if (t_rsp[c+3] !== 2'b01 || t_psel[c+3] !== 1'b0) begin
                tests_failed++;
                $display("FAIL write_rsp_timing: rsp=%b psel=%b at N+3 required 01 0", t_rsp[c+3], t_psel[c+3]);
            end
            tests_run++;
            if (t_paddr[c+1] !== 32'h10 || t_pwr[c+1] !== 1'b1 || t_pwdata[c+1] !== 32'hDEAD_BEEF) begin
                tests_failed++;
                $display("FAIL write_bus: paddr=%h pwrite=%b pwdata=%h required 10 1 deadbeef",
                         t_paddr[c+1], t_pwr[c+1], t_pwdata[c+1]);
            end
        end
        wait_idle(20);
    endtask

    task automatic test_read_wait();
        int c, n_acc;
        bit stable;
        slv_wait = 2;
        q1.push_back('{1'b0, 32'h10, 32'h0});
        trace(14);
        c = -1;
        for (int i = 6; i >= 0; i--) if (t_ready[i] === 2'b10) c = i;
        n_acc = 0;
        for (int i = 0; i < 14; i++) if (t_pen[i] === 1'b1) n_acc++;
        tests_run++;
        if (n_acc != 3) begin
            tests_failed++;
            $display("FAIL read_access_len: %0d ACCESS cycles, required 3", n_acc);
        end
        tests_run++;
        if (c < 0) begin
            tests_failed++;
            $display("FAIL read_accept: req_ready[1] never seen");
        end else begin
            stable = 1'b1;
            for (int i = 1; i <= 4; i++) if (t_paddr[c+i] !== 32'h10 || t_psel[c+i] !== 1'b1) stable = 1'b0;
            tests_run++;
            if (!stable) begin
                tests_failed++;
                $display("FAIL read_paddr_stable: paddr/psel changed during SETUP/ACCESS, required 10/1");
            end
            tests_run++;
            if (t_rsp[c+5] !== 2'b10) begin
                tests_failed++;
                $display("FAIL read_rsp_timing: rsp=%b at N+5 required 10", t_rsp[c+5]);
            end
        end
        slv_wait = 0;
        wait_idle(20);
    endtask

    task automatic test_round_robin();
        int g_cyc[$];
        int g_idx[$];
        int exp_order[4] = '{0, 1, 0, 1};
        slv_wait = 0;
        q0.push_back('{1'b1, 32'h20, 32'h1111_AAAA});
        q0.push_back('{1'b1, 32'h24, 32'h2222_BBBB});
        q1.push_back('{1'b1, 32'h30, 32'h3333_CCCC});
        q1.push_back('{1'b1, 32'h34, 32'h4444_DDDD});
        trace(20);
        for (int i = 0; i < 20; i++) begin
            if (t_ready[i] !== 2'b00) begin
                g_cyc.push_back(i);
                g_idx.push_back(t_ready[i] === 2'b01 ? 0 : (t_ready[i] === 2'b10 ? 1 : -1));
            end
        end
        tests_run++;
        if (g_cyc.size() != 4) begin
            tests_failed++;
            $display("FAIL rr_grant_count: %0d grants, required 4", g_cyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (g_idx[k] != exp_order[k] || t_psel[g_cyc[k]] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rr_grant_%0d: idx=%0d psel=%b required idx=%0d psel=0", k, g_idx[k], t_psel[g_cyc[k]], exp_order[k]);
                end
            end
            tests_run++;
            if (g_cyc[1] - g_cyc[0] != 3 || g_cyc[3] - g_cyc[2] != 3) begin
                tests_failed++;
                $display("FAIL rr_spacing: grant gaps %0d %0d required 3 3", g_cyc[1] - g_cyc[0], g_cyc[3] - g_cyc[2]);
            end
        end
        wait_idle(30);
    endtask

    task automatic test_timeout();
        int n_acc, last;
        slv_stuck = 1'b1;
        q0.push_back('{1'b0, 32'h10, 32'h0});
        trace(24);
        n_acc = 0;
        last  = -1;
        for (int i = 0; i < 24; i++) if (t_pen[i] === 1'b1) begin n_acc++; last = i; end
        tests_run++;
        if (n_acc != TO) begin
            tests_failed++;
            $display("FAIL timeout_len: %0d ACCESS cycles, required %0d", n_acc, TO);
        end
        tests_run++;
        if (last < 0 || last > 22 || t_rsp[last+1] !== 2'b01 || t_err[last+1] !== 1'b1 || t_psel[last+1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_abort: no rsp_valid=01 err=1 with psel=0 right after ACCESS (last access cycle %0d)", last);
        end
        slv_stuck = 1'b0;
        wait_idle(20);
    endtask

    task automatic test_slverr();
        logic err_seen [2];
        for (int k = 0; k < 2; k++) begin
            slv_err = (k == 0);
            q1.push_back('{1'b0, 32'h24, 32'h0});
            trace(8);
            err_seen[k] = 1'bx;
            for (int i = 0; i < 8; i++) if (t_rsp[i] === 2'b10) err_seen[k] = t_err[i];
            wait_idle(20);
        end
        slv_err = 1'b0;
        tests_run++;
        if (err_seen[0] !== 1'b1 || err_seen[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL slverr_pulse: rsp_err first=%b second=%b required 1 0", err_seen[0], err_seen[1]);
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        bit quiet;
        int c;
        slv_wait = 5;
        q0.push_back('{1'b0, 32'h30, 32'h0});
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge PCLK);
            if (apb.PENABLE === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL abort_reach_access: PENABLE never rose within 10 cycles");
        end
        PRESETn = 1'b0;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        sb_q.delete();
        slv_wait = 0;
        @(negedge PCLK);
        tests_run++;
        if (apb.PSEL !== 1'b0 || apb.PENABLE !== 1'b0 || rsp_valid !== '0) begin
            tests_failed++;
            $display("FAIL abort_bus_idle: psel=%b pen=%b rsp=%b required 0 0 00", apb.PSEL, apb.PENABLE, rsp_valid);
        end
        trace(4);
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) if (t_rsp[i] !== 2'b00) quiet = 1'b0;
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL abort_no_rsp: rsp_valid pulsed after aborted transfer, required none");
        end
        q0.push_back('{1'b1, 32'h40, 32'h5555_0000});
        q1.push_back('{1'b1, 32'h44, 32'h6666_0000});
        trace(6);
        c = -1;
        for (int i = 5; i >= 0; i--) if (t_ready[i] !== 2'b00) c = i;
        tests_run++;
        if (c < 0 || t_ready[c] !== 2'b01) begin
            tests_failed++;
            $display("FAIL abort_pointer_reset: first grant req_ready=%b required 01", (c < 0) ? 2'b00 : t_ready[c]);
        end
        wait_idle(30);
    endtask

    initial begin : main
        PRESETn = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_round_robin();
        test_timeout();
        test_slverr();
        test_reset_abort();
        repeat (3) @(posedge PCLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
